// File: rtl/bus_driver_arbiter_if.sv
// Bundle of the source-side and consumer-side signals of the bus arbiter.
//   slave  : arbiter view (sources and err_clr in, bus and debug status out)
//   master : driver view, the source units plus the bus consumers
//   src_data          packed source words, source i at [i*WIDTH +: WIDTH]
//   src_ena           gate enables, one per source
//   err_clr           synchronous clear of the contention debug state
//   bus / bus_valid / grant                         resolved bus, aligned with each other
//   contention / contention_sticky / contention_cnt contention debug outputs
interface bus_driver_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int N_SRC = 4,
  parameter int CNT_W = 8
);
  logic [N_SRC*WIDTH-1:0] src_data;
  logic [N_SRC-1:0]       src_ena;
  logic                   err_clr;
  logic [WIDTH-1:0]       bus;
  logic                   bus_valid;
  logic [N_SRC-1:0]       grant;
  logic                   contention;
  logic                   contention_sticky;
  logic [CNT_W-1:0]       contention_cnt;

  modport slave (
    input  src_data, src_ena, err_clr,
    output bus, bus_valid, grant, contention, contention_sticky, contention_cnt
  );

  modport master (
    output src_data, src_ena, err_clr,
    input  bus, bus_valid, grant, contention, contention_sticky, contention_cnt
  );
endinterface

// File: rtl/bus_driver_arbiter.sv
// Fixed-priority gate of N_SRC sources onto the shared datapath bus.
// Source 0 has the highest priority. When no gate is enabled, the bus shows
// the last value driven onto it, which comes from a clocked hold register.
// Asserting more than one gate is flagged as contention, with a one-cycle
// pulse, a sticky flag and a saturating event counter.
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bif   bus_driver_arbiter_if.slave (sources, err_clr, bus, grant, status)
// REG_OUT=0 gives a combinational bus with zero latency. REG_OUT=1 registers
// bus, grant and bus_valid, so they follow src_ena by one cycle.
module bus_driver_arbiter #(
  parameter int               WIDTH     = 16,
  parameter int               N_SRC     = 4,
  parameter bit               REG_OUT   = 1'b0,
  parameter int               CNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                  clk,
  input logic                  rst_n,
  bus_driver_arbiter_if.slave  bif
);

  if (N_SRC < 2) begin : g_bad_nsrc
    $error("bus_driver_arbiter: N_SRC must be >= 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("bus_driver_arbiter: WIDTH must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cntw
    $error("bus_driver_arbiter: CNT_W must be >= 1");
  end

  logic [WIDTH-1:0] win_data;
  logic [N_SRC-1:0] grant_c;
  logic             any_ena;
  logic             multi;
  logic             found;

  logic [WIDTH-1:0] hold_q;
  logic             contention_q;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;

  assign any_ena = |bif.src_ena;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi   = |(bif.src_ena & (bif.src_ena - N_SRC'(1)));

  // Lowest index wins. This stays a clean mux even during contention.
  always_comb begin
    win_data = '0;
    grant_c  = '0;
    found    = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (bif.src_ena[i] && !found) begin
        found      = 1'b1;
        grant_c[i] = 1'b1;
        win_data   = bif.src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // The hold register stands in for the old transparent latch. In registered
  // mode it is also the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= RESET_VAL;
    end else if (any_ena) begin
      hold_q <= win_data;
    end
  end

  // A contention event on the same edge as err_clr wins, so the event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contention_q <= 1'b0;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      contention_q <= multi;
      if (multi) begin
        sticky_q <= 1'b1;
        if (bif.err_clr) begin
          cnt_q <= CNT_W'(1);
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else if (bif.err_clr) begin
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end
    end
  end

  if (REG_OUT) begin : g_reg_out
    logic [N_SRC-1:0] grant_q;
    logic             valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        grant_q <= '0;
        valid_q <= 1'b0;
      end else begin
        grant_q <= grant_c;
        valid_q <= any_ena;
      end
    end

    assign bif.bus       = hold_q;
    assign bif.grant     = grant_q;
    assign bif.bus_valid = valid_q;
  end else begin : g_comb_out
    assign bif.bus       = any_ena ? win_data : hold_q;
    assign bif.grant     = grant_c;
    assign bif.bus_valid = any_ena;
  end

  assign bif.contention        = contention_q;
  assign bif.contention_sticky = sticky_q;
  assign bif.contention_cnt    = cnt_q;

endmodule
